// File: rtl/cla_mul_sequencer.sv
// cla_mul_sequencer: iterative 32x32 unsigned shift-add multiplier built around one
// 32-bit carry-lookahead adder made of 4-bit groups and two levels of lookahead carry units.
// Each RUN cycle uses the adder once. 32 iterations run for every operand pair, so the
// latency does not depend on the data.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   in_valid  - operand pair on a/b is valid
//   in_ready  - accepting operands (IDLE only)
//   a, b      - 32-bit unsigned multiplicand / multiplier
//   out_valid - product valid (DONE only)
//   out_ready - consumer accepts product
//   product   - registered 64-bit result {acc_hi, acc_lo}
//   busy      - RUN or DONE
module cla_mul_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] product,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e      state_q, state_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] acc_hi_q, acc_hi_d;
   logic [31:0] acc_lo_q, acc_lo_d;
   logic [4:0]  cnt_q, cnt_d;

   // Carries c1..c3 inside a 4-wide lookahead block, flattened from generate/propagate.
   function automatic logic [2:0] lcu_int(input logic [3:0] g, input logic [3:0] p,
                                          input logic c);
      logic [2:0] r;
      r[0] = g[0] | (p[0] & c);
      r[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      r[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
      return r;
   endfunction

   // Block generate: carry out of a 4-wide block with zero carry-in.
   function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
      return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   endfunction

   // ---------------- Carry-lookahead adder ----------------
   logic [31:0] add_a, add_b, bit_g, bit_p, carry, sum;
   logic [7:0]  grp_g, grp_p, grp_c;
   logic        sg0, sp0, sg1, sp1, cout;
   logic        cin;

   always_comb begin
      add_a = acc_hi_q;
      add_b = acc_lo_q[0] ? mcand_q : 32'h0;
      cin   = 1'b0;
      bit_g = add_a & add_b;
      bit_p = add_a ^ add_b;

      for (int j = 0; j < 8; j++) begin
         grp_g[j] = grp_gen(bit_g[4*j +: 4], bit_p[4*j +: 4]);
         grp_p[j] = &bit_p[4*j +: 4];
      end

      // Second level: two 4-group units, combined by a top-level unit.
      sg0 = grp_gen(grp_g[3:0], grp_p[3:0]);
      sp0 = &grp_p[3:0];
      sg1 = grp_gen(grp_g[7:4], grp_p[7:4]);
      sp1 = &grp_p[7:4];

      grp_c[0]   = cin;
      grp_c[3:1] = lcu_int(grp_g[3:0], grp_p[3:0], cin);
      grp_c[4]   = sg0 | (sp0 & cin);
      grp_c[7:5] = lcu_int(grp_g[7:4], grp_p[7:4], grp_c[4]);
      cout       = sg1 | (sp1 & sg0) | (sp1 & sp0 & cin);

      for (int j = 0; j < 8; j++) begin
         carry[4*j]       = grp_c[j];
         carry[4*j+1 +: 3] = lcu_int(bit_g[4*j +: 4], bit_p[4*j +: 4], grp_c[j]);
      end

      sum = bit_p ^ carry;
   end

   // ---------------- Sequencer ----------------
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      cnt_d    = cnt_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               mcand_d  = a;
               acc_hi_d = 32'h0;
               acc_lo_d = b;
               cnt_d    = 5'd0;
               state_d  = StRun;
            end
         end
         StRun: begin
            // 33-bit {cout, sum} shifted right by one into the accumulator pair.
            {acc_hi_d, acc_lo_d} = {cout, sum, acc_lo_q[31:1]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         mcand_q  <= 32'h0;
         acc_hi_q <= 32'h0;
         acc_lo_q <= 32'h0;
         cnt_q    <= 5'd0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         cnt_q    <= cnt_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign product   = {acc_hi_q, acc_lo_q};

endmodule

// File: tb/tb_cla_mul_sequencer.sv
module tb_cla_mul_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = 32'h0;
   logic [31:0] b = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] product;
   logic        busy;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   cla_mul_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_reset(input string name);
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL %s in_ready: got %b want 1", name, in_ready);
      end
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL %s out_valid: got %b want 0", name, out_valid);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL %s busy: got %b want 0", name, busy);
      end
      total++;
      if (product !== 64'h0) begin
         bad++; $display("FAIL %s product: got %h want 0", name, product);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_idle_reset("reset");
   endtask

   // Issue one pair, check latency, result and handshake, then drain it.
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_in,
                         input logic [63:0] exp, input string name);
      int lat;
      bit rdy_seen;
      a = ta;
      b = tb_in;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      total++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL %s after_accept: in_ready=%b busy=%b want 0/1", name, in_ready, busy);
      end
      lat = 0;
      rdy_seen = 1'b0;
      while (out_valid !== 1'b1 && lat < 100) begin
         if (in_ready !== 1'b0) rdy_seen = 1'b1;
         tick();
         lat++;
      end
      total++;
      if (lat != 32) begin
         bad++; $display("FAIL %s latency: got %0d want 32", name, lat);
      end
      total++;
      if (product !== exp) begin
         bad++; $display("FAIL %s product: got %h want %h", name, product, exp);
      end
      total++;
      if (rdy_seen || in_ready !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL %s ready_in_run: got rdy_seen=%b in_ready=%b busy=%b want 0/0/1",
                         name, rdy_seen, in_ready, busy);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL %s drain: in_ready=%b out_valid=%b busy=%b want 1/0/0",
                         name, in_ready, out_valid, busy);
      end
   endtask

   task automatic test_basic();
      run_op(32'd3, 32'd5, 64'h000000000000000F, "basic");
   endtask

   task automatic test_max();
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, "max");
   endtask

   task automatic test_zero_identity();
      run_op(32'h0, 32'hDEADBEEF, 64'h0, "zero");
      run_op(32'h12345678, 32'h1, 64'h0000000012345678, "ident_b1");
      run_op(32'h1, 32'h80000000, 64'h0000000080000000, "ident_msb");
   endtask

   task automatic test_backpressure();
      int lat;
      a = 32'd6;
      b = 32'd7;
      in_valid = 1'b1;
      tick();
      // Keep in_valid high with different operands through RUN and DONE.
      a = 32'd100;
      b = 32'd200;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      total++;
      if (lat != 32) begin
         bad++; $display("FAIL bp_latency: got %0d want 32", lat);
      end
      for (int i = 0; i < 10; i++) begin
         a = $urandom;
         b = $urandom;
         tick();
         total++;
         if (out_valid !== 1'b1 || product !== 64'd42) begin
            bad++; $display("FAIL bp_hold cycle %0d: out_valid=%b product=%h want 1/%h",
                            i, out_valid, product, 64'd42);
         end
      end
      a = 32'd11;
      b = 32'd13;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL bp_eh_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
      tick();
      in_valid = 1'b0;
      total++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         bad++; $display("FAIL bp_accept_eh1: busy=%b in_ready=%b want 1/0", busy, in_ready);
      end
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      total++;
      if (lat != 32 || product !== 64'd143) begin
         bad++; $display("FAIL bp_pending: latency=%0d product=%h want 32/%h", lat, product, 64'd143);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit seen_valid;
      a = 32'd7;
      b = 32'd9;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 17; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle_reset("reset_mid");
      seen_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (out_valid !== 1'b0) seen_valid = 1'b1;
      end
      total++;
      if (seen_valid) begin
         bad++; $display("FAIL reset_mid_no_valid: got out_valid=1 want 0");
      end
      run_op(32'd7, 32'd9, 64'd63, "after_reset");
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_q[$];
      int got;
      got = 0;
      fork
         begin : producer
            logic [31:0] ra, rb;
            for (int i = 0; i < 1000; i++) begin
               int w;
               w = 0;
               while (in_ready !== 1'b1 && w < 200) begin
                  tick();
                  w++;
               end
               if (w >= 200) begin
                  total++; bad++;
                  $display("FAIL b2b_in_ready_timeout: got in_ready=%b want 1", in_ready);
                  break;
               end
               ra = $urandom;
               rb = $urandom;
               a = ra;
               b = rb;
               in_valid = 1'b1;
               exp_q.push_back({32'h0, ra} * {32'h0, rb});
               tick();
               in_valid = 1'b0;
               repeat ($urandom_range(0, 2)) tick();
            end
         end
         begin : consumer
            int cyc;
            cyc = 0;
            while (got < 1000 && cyc < 80000) begin
               tick();
               cyc++;
               out_ready = ($urandom_range(0, 3) != 0);
               if (out_valid === 1'b1 && out_ready) begin
                  total++;
                  if (exp_q.size() == 0) begin
                     bad++; $display("FAIL b2b_extra_result: got %h want none", product);
                  end else begin
                     if (product !== exp_q[0]) begin
                        bad++; $display("FAIL b2b_product #%0d: got %h want %h",
                                        got, product, exp_q[0]);
                     end
                     void'(exp_q.pop_front());
                  end
                  got++;
               end
            end
            tick();
            out_ready = 1'b0;
         end
      join
      total++;
      if (got != 1000 || exp_q.size() != 0) begin
         bad++; $display("FAIL b2b_count: got %0d results, %0d pending want 1000/0",
                         got, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max();
      test_zero_identity();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
